// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- BIST sequencer with 2-cycle read compare pipeline and first-fail capture
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_element,
  output logic [CNT_WIDTH-1:0]  fail_count
);
  typedef enum logic [2:0] {IDLE, PREP, RUN, DRAIN, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] CAP = ADDR_WIDTH'(CAPACITY);
  state_t state_q, state_d;
  // elem/addr/ph point at the op to issue next; elem 6 means the march is exhausted
  logic [2:0] elem_q, elem_d, cur_elem_q, cur_elem_d, elem1_q, elem1_d, elem2_q, elem2_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, maddr_q, maddr_d, addr1_q, addr1_d, addr2_q, addr2_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0] fail_cnt_q, fail_cnt_d;
  logic [2:0] fail_elem_q, fail_elem_d;
  logic ph_q, ph_d, drain_q, drain_d, we_q, we_d, cur_bg_q, cur_bg_d;
  logic v1_q, v1_d, v2_q, v2_d, bg1_q, bg1_d, bg2_q, bg2_d;
  logic busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic single, down, last_addr, step, nx_down, nx_ph, bg_p, bg_nx, wr_p, mism;
  logic [2:0] nx_elem;
  logic [ADDR_WIDTH-1:0] nx_addr;
  always_comb begin
    single    = (elem_q == 3'd0) || (elem_q == 3'd5);
    down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    last_addr = down ? (addr_q == '0) : (addr_q == CAP);
    step      = single || ph_q;
    nx_elem   = (step && last_addr) ? elem_q + 3'd1 : elem_q;
    nx_down   = (nx_elem == 3'd3) || (nx_elem == 3'd4);
    nx_addr   = !step ? addr_q : last_addr ? (nx_down ? CAP : '0) :
                down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
    nx_ph     = !step;
    bg_p      = ph_q ? (elem_q == 3'd1 || elem_q == 3'd3) : (elem_q == 3'd2 || elem_q == 3'd4);
    bg_nx     = nx_ph ? (nx_elem == 3'd1 || nx_elem == 3'd3) : (nx_elem == 3'd2 || nx_elem == 3'd4);
    wr_p      = (elem_q == 3'd0) || ph_q;
    mism      = v2_q && (mem_rdata != {DATA_WIDTH{bg2_q}});
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    ph_d        = ph_q;
    drain_d     = drain_q;
    we_d        = 1'b0;
    maddr_d     = '0;
    wdata_d     = '0;
    cur_bg_d    = bg_p;
    cur_elem_d  = elem_q;
    busy_d      = busy_q;
    done_d      = done_q;
    v1_d        = (state_q == RUN) && !we_q;
    bg1_d       = cur_bg_q;
    addr1_d     = maddr_q;
    elem1_d     = cur_elem_q;
    v2_d        = v1_q;
    bg2_d       = bg1_q;
    addr2_d     = addr1_q;
    elem2_d     = elem1_q;
    fail_d      = fail_q || mism;
    fail_addr_d = (mism && !fail_q) ? addr2_q : fail_addr_q;
    fail_elem_d = (mism && !fail_q) ? elem2_q : fail_elem_q;
    fail_cnt_d  = (mism && !(&fail_cnt_q)) ? fail_cnt_q + CNT_WIDTH'(1) : fail_cnt_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d     = PREP;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        elem_d      = 3'd0;
        addr_d      = '0;
        ph_d        = 1'b0;
        fail_d      = 1'b0;
        fail_addr_d = '0;
        fail_elem_d = 3'd0;
        fail_cnt_d  = '0;
      end
      PREP, RUN: if (elem_q != 3'd6) begin
        state_d = RUN;
        we_d    = wr_p;
        maddr_d = addr_q;
        wdata_d = {DATA_WIDTH{bg_nx}};
        elem_d  = nx_elem;
        addr_d  = nx_addr;
        ph_d    = nx_ph;
      end else begin
        state_d = DRAIN;
        drain_d = 1'b0;
      end
      DRAIN: begin
        drain_d = 1'b1;
        state_d = drain_q ? DONE : DRAIN;
        busy_d  = !drain_q;
        done_d  = drain_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      ph_q        <= 1'b0;
      drain_q     <= 1'b0;
      we_q        <= 1'b0;
      maddr_q     <= '0;
      wdata_q     <= '0;
      cur_bg_q    <= 1'b0;
      cur_elem_q  <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      bg1_q       <= 1'b0;
      bg2_q       <= 1'b0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      elem1_q     <= '0;
      elem2_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      ph_q        <= ph_d;
      drain_q     <= drain_d;
      we_q        <= we_d;
      maddr_q     <= maddr_d;
      wdata_q     <= wdata_d;
      cur_bg_q    <= cur_bg_d;
      cur_elem_q  <= cur_elem_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      bg1_q       <= bg1_d;
      bg2_q       <= bg2_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      elem1_q     <= elem1_d;
      elem2_q     <= elem2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end
  assign mem_write_read = we_q;
  assign mem_address    = maddr_q;
  assign mem_wdata      = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign fail_addr      = fail_addr_q;
  assign fail_element   = fail_elem_q;
  assign fail_count     = fail_cnt_q;
endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

March C- memory BIST controller for a single-port synchronous memory macro with a 1-cycle write-data register and 2-cycle read latency (fault_mem-style interface). On `start` it sequences every address through the six March C- elements, compares read data against expected backgrounds, and reports pass/fail with first-failure diagnostics. It sits between the test access logic and the memory under test and owns the memory port for the duration of a test.

## Interface
- DATA_WIDTH, 8, memory word width
- ADDR_WIDTH, 4, memory address width
- CAPACITY, 15, highest valid address; tested range is 0..CAPACITY
- CNT_WIDTH, 8, width of the failure counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin test; sampled only in IDLE or DONE
- mem_write_read  out  1  1 = write, 0 = read, to memory
- mem_address  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data, driven one cycle ahead of its write
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  test in progress
- done  out  1  test complete, held until next start or reset
- fail  out  1  sticky: at least one mismatch this test
- fail_addr  out  ADDR_WIDTH  address of first mismatch
- fail_element  out  3  March element index (0-5) of first mismatch
- fail_count  out  CNT_WIDTH  number of mismatching reads, saturating

## Operation
- States: IDLE -> PREP -> RUN -> DRAIN -> DONE; DONE -> PREP on start.
- IDLE: all outputs 0. start=1 -> PREP; clears fail, fail_addr, fail_element, fail_count.
- PREP (1 cycle): busy=1, mem_write_read=0, mem_wdata = all-zeros (data for the first write).
- RUN, elements in order (0 = all zeros, 1 = all ones): E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
- One memory op per cycle, no idle cycles between ops or elements. Two-op elements: read then write to the same address on consecutive cycles. Up = 0..CAPACITY, down = CAPACITY..0. Address counter wraps at the element boundary.
- mem_wdata in cycle N carries the write value of the op issued in cycle N+1. Its value is don't-care when op N+1 is a read, but must hold the background of the next op.
- Read issued in cycle N: the controller carries expected data, address, and element through a 2-deep valid pipeline and compares mem_rdata at the end of cycle N+2.
- On mismatch: fail<=1, fail_count increments and saturates at all-ones. fail_addr and fail_element load only on the first mismatch.
- DRAIN (2 cycles): mem_write_read=0, busy=1, completes the outstanding compares.
- DONE: busy=0, done=1, mem_write_read=0. Results hold until start or rst.
- start while busy is ignored.
- Outside RUN, mem_write_read=0 and mem_address=0, so the memory is never written.

## Timing
- Reset (rst=1 at an edge): state IDLE; every output 0. Effective mid-test too: the test aborts, memory contents are undefined, and no done is given.
- start=1 in cycle 0 -> PREP in cycle 1 -> RUN in cycles 2..(1+10*(CAPACITY+1)) -> DRAIN for 2 cycles -> done=1 from cycle 10*(CAPACITY+1)+4.
- Total RUN ops = 10*(CAPACITY+1): E0 and E5 have 1 op per address, E1-E4 have 2.
- busy rises the cycle after start is sampled and falls in the same cycle done rises.
- Read-after-write to the same address on consecutive cycles (element boundaries E2->E3, E4->E5) must return the new data. The memory commits a write at the edge ending its cycle.

## Test plan
- Fault-free memory, CAPACITY=15, start pulse -> done rises exactly 164 cycles after the start edge; fail=0, fail_count=0; 160 RUN ops with 80 writes.
- Stuck-at-1 on bit 3 at address 5 (reads/writes ORed with 8'h08) -> fail=1, fail_addr=5, fail_element=1, fail_count=3 (r0 in E1, E3, E5).
- Stuck-at-0 on bit 0 at address 15 -> fail_addr=15, fail_element=2, fail_count=2 (r1 in E2, E4).
- Check the port cycle-by-cycle in E3: mem_address goes 15,15,14,14,...; read/write alternate; mem_wdata=8'hFF one cycle before each write.
- rst asserted mid-E2, then released -> all outputs 0 next cycle; a subsequent start runs a full test with correct result and cycle count.
- start held high through the test -> ignored while busy; done asserts; the next cycle re-enters PREP, clears fail, and a second test runs.
